// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator over raster-order pixels with two line buffers.
// Define CWG_FRAME_DONE_EN to add the frame_done pulse on the last window of each frame.
module conv_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8:0][WIDTH-1:0] window
`ifdef CWG_FRAME_DONE_EN
    ,
    output logic                  frame_done
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_TWO  = CW'(2);
    localparam logic [RW-1:0] R_TWO  = RW'(2);

    logic [CW-1:0]          c_q, c_d;
    logic [RW-1:0]          r_q, r_d;
    logic                   ov_q, ov_d;
    logic [8:0][WIDTH-1:0]  win_q, win_d;
    logic [WIDTH-1:0]       lb0_q [IMG_W];
    logic [WIDTH-1:0]       lb1_q [IMG_W];
    logic [2:0][WIDTH-1:0]  col_new;
    logic                   accept;
    logic                   emit;
    logic                   last_px;

    assign in_ready  = !ov_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign emit      = (r_q >= R_TWO) && (c_q >= C_TWO);
    assign last_px   = (r_q == R_LAST) && (c_q == C_LAST);
    // Lane 0 is the oldest row (two rows up), lane 2 the incoming pixel.
    assign col_new   = {in_data, lb0_q[c_q], lb1_q[c_q]};
    assign out_valid = ov_q;
    assign window    = win_q;

    always_comb begin
        c_d   = c_q;
        r_d   = r_q;
        ov_d  = ov_q;
        win_d = win_q;
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
                win_d[3*i+2] = col_new[i];
            end
            if (emit) begin
                ov_d = 1'b1;
            end
            if (c_q == C_LAST) begin
                c_d = '0;
                r_d = (r_q == R_LAST) ? '0 : r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

`ifdef CWG_FRAME_DONE_EN
    logic fd_q, fd_d;

    // Pulses only on the accept edge, so a stalled last window shows it once.
    assign fd_d       = accept && last_px;
    assign frame_done = fd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fd_q <= 1'b0;
        end else begin
            fd_q <= fd_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= '0;
            r_q   <= '0;
            ov_q  <= 1'b0;
            win_q <= '0;
        end else begin
            c_q   <= c_d;
            r_q   <= r_d;
            ov_q  <= ov_d;
            win_q <= win_d;
        end
    end

    // Line buffers carry no reset; rows 0-1 refill them before use.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb1_q[c_q] <= lb0_q[c_q];
            lb0_q[c_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen against an image-array reference model.
// Build with CWG_FRAME_DONE_EN defined to also check the frame_done pulse.
module tb_conv_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 32;

    typedef struct {
        logic [9*DW-1:0] w;
        bit              last;
    } ent_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic                out_valid;
    logic                out_ready;
    logic [8:0][DW-1:0]  window;
`ifdef CWG_FRAME_DONE_EN
    logic                frame_done;
`endif

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .window    (window)
`ifdef CWG_FRAME_DONE_EN
        ,
        .frame_done(frame_done)
`endif
    );

    always #5 clk = ~clk;

    int              n_chk  = 0;
    int              n_fail = 0;
    int              n_fd   = 0;
    int              k      = 0;
    bit              fresh  = 0;
    logic [DW-1:0]   img [H][W];
    ent_t            exp_q [$];
    logic [DW-1:0]   pix_q [$];
    logic [9*DW-1:0] got_q [$];

    int rw [4][9] = '{
        '{1, 2, 3, 5, 6, 7, 9, 10, 11},
        '{2, 3, 4, 6, 7, 8, 10, 11, 12},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15},
        '{6, 7, 8, 10, 11, 12, 14, 15, 16}
    };

    task automatic check(input string tag, input logic [9*DW-1:0] got,
                         input logic [9*DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pack9(input int idx);
        logic [9*DW-1:0] w;
        for (int n = 0; n < 9; n++) w[DW*n +: DW] = DW'(rw[idx][n]);
        return w;
    endfunction

    // Reference: store each accepted pixel at its raster position and
    // emit the 3x3 neighbourhood whenever the pixel is at row>=2, col>=2.
    task automatic model_accept(input logic [DW-1:0] d);
        int r, c;
        ent_t e;
        r = k / W;
        c = k % W;
        img[r][c] = d;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.w[DW*(3*i+j) +: DW] = img[r-2+i][c-2+j];
            e.last = (r == H-1) && (c == W-1);
            exp_q.push_back(e);
            fresh = 1;
        end
        k = (k + 1) % (W * H);
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit ordy,
                        input bit rs, output bit acc);
        bit mv;
        @(negedge clk);
        mv = exp_q.size() != 0;
        check("out_valid", out_valid, mv);
        if (mv) check("window", window, exp_q[0].w);
`ifdef CWG_FRAME_DONE_EN
        check("frame_done", frame_done, mv && fresh && exp_q[0].last);
        if (frame_done) n_fd++;
`endif
        fresh     = 0;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rst       = rs;
        #1;
        check("in_ready", in_ready, !mv || ordy);
        acc = 0;
        if (rs) begin
            exp_q.delete();
            k = 0;
        end else begin
            if (mv && ordy) begin
                got_q.push_back(exp_q[0].w);
                check("consumed", window, exp_q[0].w);
                void'(exp_q.pop_front());
            end
            acc = v && (!mv || ordy);
            if (acc) model_accept(d);
        end
    endtask

    task automatic run(input int vprob, input int rprob, input bit stall_first);
        int hold;
        int cyc;
        bit armed;
        bit v, ordy, acc;
        hold  = 0;
        cyc   = 0;
        armed = stall_first;
        while ((pix_q.size() != 0 || exp_q.size() != 0) && cyc < 2000) begin
            v    = pix_q.size() != 0 && ($urandom_range(0, 99) < vprob);
            ordy = $urandom_range(0, 99) < rprob;
            if (armed && exp_q.size() != 0) begin
                armed = 0;
                hold  = 3;
            end
            if (hold > 0) begin
                ordy = 0;
                hold--;
            end
            step(v, v ? pix_q[0] : $urandom, ordy, 0, acc);
            if (acc) void'(pix_q.pop_front());
            cyc++;
        end
        check("run_drained", pix_q.size() + exp_q.size(), 0);
    endtask

    task automatic load_seq();
        for (int n = 0; n < W * H; n++) pix_q.push_back(DW'(n + 1));
    endtask

    task automatic check_seq(input string tag, input int base);
        for (int n = 0; n < 4; n++) begin
            if (got_q.size() > base + n)
                check(tag, got_q[base+n], pack9(n));
        end
    endtask

    initial begin
        logic [9*DW-1:0] tmp;
        bit acc;
        rst       = 1;
        in_valid  = 0;
        in_data   = '0;
        out_ready = 0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, acc);
        check("rst_window", window, '0);

        // Plain frame, downstream always ready
        got_q.delete();
        load_seq();
        run(100, 100, 0);
        check("t1_nwin", got_q.size(), 4);
        check_seq("t1_win", 0);

        // Stall for 3 cycles after the first window
        got_q.delete();
        load_seq();
        run(100, 100, 1);
        check("t2_nwin", got_q.size(), 4);
        check_seq("t2_win", 0);

        // Negative value passes bit-exact
        got_q.delete();
        for (int n = 0; n < W * H; n++)
            pix_q.push_back((n == 2*W + 2) ? -32'sd4 : 32'd1);
        run(100, 100, 0);
        check("t3_nwin", got_q.size(), 4);
        tmp = got_q[0];
        check("t3_lane8", tmp[9*DW-1 -: DW], 32'hFFFFFFFC);
        check("t3_others", tmp[8*DW-1:0], {8{32'd1}});

        // Reset mid-frame with a concurrent valid pixel
        got_q.delete();
        for (int n = 0; n < 6; n++) step(1, DW'(n + 1), 1, 0, acc);
        step(1, 32'd99, 1, 1, acc);
        check("t4_rst_acc", acc, 0);
        load_seq();
        run(100, 100, 0);
        check("t4_nwin", got_q.size(), 4);
        check_seq("t4_win", 0);

        // Two back-to-back frames
        got_q.delete();
        n_fd = 0;
        load_seq();
        load_seq();
        run(100, 100, 0);
        check("t5_nwin", got_q.size(), 8);
        check_seq("t5_f1", 0);
        check_seq("t5_f2", 4);
`ifdef CWG_FRAME_DONE_EN
        check("t5_fd_cnt", n_fd, 2);
`endif

        // Random data with random valid/ready gaps
        got_q.delete();
        for (int n = 0; n < 3 * W * H; n++) pix_q.push_back($urandom);
        run(80, 70, 0);
        check("t6_nwin", got_q.size(), 12);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
